// File: rtl/rep_upload_arb.sv
// rep_upload_arb: packet-atomic arbiter sharing the reply FIFO between the
// memory reply uploader (m_*) and the data-cache reply uploader (d_*).
// A whole packet is granted at a time, round-robin between packets, with
// sticky flags for bad headers and over-long packets.
module rep_upload_arb #(
    parameter int MAX_FLITS = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] m_flit_in,
    input  logic        v_m_flit_in,
    input  logic [1:0]  m_ctrl_in,
    input  logic [15:0] d_flit_in,
    input  logic        v_d_flit_in,
    input  logic [1:0]  d_ctrl_in,
    input  logic        fifo_rdy,
    output logic        m_rdy,
    output logic        d_rdy,
    output logic [15:0] flit_out,
    output logic        v_flit_out,
    output logic [1:0]  ctrl_out,
    output logic        arb_busy,
    output logic        owner,
    output logic        err_len,
    output logic        err_hdr
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_M = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;

    localparam logic [1:0] CTRL_HEAD = 2'b01;
    localparam logic [1:0] CTRL_TAIL = 2'b11;

    // Index of the last flit a packet may carry before it is cut off.
    localparam logic [3:0] LAST_IDX = 4'(MAX_FLITS - 1);

    logic [1:0]  r_state;
    logic        r_rr_ptr;
    logic [3:0]  r_len_cnt;
    logic        r_owner;
    logic        r_err_len;
    logic        r_err_hdr;

    logic        w_granted;
    logic [15:0] w_sel_flit;
    logic [1:0]  w_sel_ctrl;
    logic        w_sel_valid;
    logic        w_xfer;
    logic        w_at_limit;
    logic        w_is_tail;
    logic        w_overrun;
    logic        w_pkt_end;
    logic        w_bad_hdr;
    logic [1:0]  w_next_state;
    logic        w_next_owner;

    // Select the owner's flit and work out whether this cycle writes, ends
    // the packet, or trips one of the framing checks.
    always_comb begin
        w_granted   = (r_state != ST_IDLE);
        w_sel_flit  = r_owner ? d_flit_in   : m_flit_in;
        w_sel_ctrl  = r_owner ? d_ctrl_in   : m_ctrl_in;
        w_sel_valid = r_owner ? v_d_flit_in : v_m_flit_in;
        w_xfer      = w_granted & w_sel_valid & fifo_rdy;
        w_at_limit  = (r_len_cnt == LAST_IDX);
        w_is_tail   = (w_sel_ctrl == CTRL_TAIL);
        w_overrun   = w_xfer & w_at_limit & ~w_is_tail;
        w_pkt_end   = w_xfer & (w_is_tail | w_at_limit);
        w_bad_hdr   = w_xfer & (r_len_cnt == 4'd0) &
                      (w_sel_ctrl != CTRL_HEAD) & ~w_is_tail;
    end

    // Drive the FIFO side and the uploader handshakes; an over-long packet
    // is closed off by rewriting its last flit as a tail.
    always_comb begin
        m_rdy      = (r_state == ST_GNT_M) & fifo_rdy;
        d_rdy      = (r_state == ST_GNT_D) & fifo_rdy;
        v_flit_out = w_xfer;
        flit_out   = w_granted ? w_sel_flit : 16'd0;
        ctrl_out   = 2'b00;
        if (w_granted) begin
            ctrl_out = w_overrun ? CTRL_TAIL : w_sel_ctrl;
        end
        arb_busy   = w_granted;
        owner      = r_owner;
        err_len    = r_err_len;
        err_hdr    = r_err_hdr;
    end

    // Choose the next grant: in IDLE pick a requester (round-robin on a
    // tie), while granted hold until the packet ends.
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        case (r_state)
            ST_IDLE: begin
                if (v_m_flit_in && v_d_flit_in) begin
                    w_next_state = r_rr_ptr ? ST_GNT_D : ST_GNT_M;
                    w_next_owner = r_rr_ptr;
                end else if (v_m_flit_in) begin
                    w_next_state = ST_GNT_M;
                    w_next_owner = 1'b0;
                end else if (v_d_flit_in) begin
                    w_next_state = ST_GNT_D;
                    w_next_owner = 1'b1;
                end
            end
            ST_GNT_M, ST_GNT_D: begin
                if (w_pkt_end) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, packet length tracking and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= 1'b0;
            r_len_cnt <= 4'd0;
            r_owner   <= 1'b0;
            r_err_len <= 1'b0;
            r_err_hdr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_owner <= w_next_owner;
            if (w_pkt_end) begin
                r_rr_ptr  <= ~r_owner;
                r_len_cnt <= 4'd0;
            end else if (w_xfer) begin
                r_len_cnt <= r_len_cnt + 4'd1;
            end
            if (w_overrun) begin
                r_err_len <= 1'b1;
            end
            if (w_bad_hdr) begin
                r_err_hdr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rep_upload_arb.sv
// tb_rep_upload_arb: directed bench for rep_upload_arb. Two uploader models
// feed flits from queues and honour the rdy handshake; every FIFO write is
// matched against a scoreboard of expected flits in the predicted order.
module tb_rep_upload_arb;

    localparam int MAXF = 9;

    typedef struct packed {
        logic [15:0] f;
        logic [1:0]  c;
    } flit_t;

    logic        clk;
    logic        rst;
    logic [15:0] m_flit_in;
    logic        v_m_flit_in;
    logic [1:0]  m_ctrl_in;
    logic [15:0] d_flit_in;
    logic        v_d_flit_in;
    logic [1:0]  d_ctrl_in;
    logic        fifo_rdy;
    logic        m_rdy;
    logic        d_rdy;
    logic [15:0] flit_out;
    logic        v_flit_out;
    logic [1:0]  ctrl_out;
    logic        arb_busy;
    logic        owner;
    logic        err_len;
    logic        err_hdr;

    flit_t mQ[$];
    flit_t dQ[$];
    flit_t expQ[$];

    int nAsserts = 0;
    int nFails   = 0;

    logic lastBusy, lastVout, lastMrdy, lastDrdy, lastOwner;
    logic lastErrLen, lastErrHdr;
    logic [1:0] lastCtrl;
    logic accM, accD;

    rep_upload_arb #(.MAX_FLITS(MAXF)) dut (
        .clk        (clk),
        .rst        (rst),
        .m_flit_in  (m_flit_in),
        .v_m_flit_in(v_m_flit_in),
        .m_ctrl_in  (m_ctrl_in),
        .d_flit_in  (d_flit_in),
        .v_d_flit_in(v_d_flit_in),
        .d_ctrl_in  (d_ctrl_in),
        .fifo_rdy   (fifo_rdy),
        .m_rdy      (m_rdy),
        .d_rdy      (d_rdy),
        .flit_out   (flit_out),
        .v_flit_out (v_flit_out),
        .ctrl_out   (ctrl_out),
        .arb_busy   (arb_busy),
        .owner      (owner),
        .err_len    (err_len),
        .err_hdr    (err_hdr)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue one flit at an uploader; optionally record what the FIFO should see.
    task automatic pushFlit(input bit isD, input logic [15:0] f, input logic [1:0] c,
                            input logic [1:0] expC, input bit doExp);
        flit_t fl;
        flit_t ex;
        fl.f = f;
        fl.c = c;
        ex.f = f;
        ex.c = expC;
        if (isD) dQ.push_back(fl);
        else     mQ.push_back(fl);
        if (doExp) expQ.push_back(ex);
    endtask

    // Queue a well-formed packet of n flits (n==1 gives a lone tail).
    task automatic pushPacket(input bit isD, input int n, input logic [15:0] base);
        logic [1:0] c;
        for (int i = 0; i < n; i++) begin
            if (i == n - 1)  c = 2'b11;
            else if (i == 0) c = 2'b01;
            else             c = 2'b10;
            pushFlit(isD, base + 16'(i), c, c, 1'b1);
        end
    endtask

    // Present the head of each uploader queue, holding it until accepted.
    task automatic applyStimulus();
        v_m_flit_in = (mQ.size() != 0);
        m_flit_in   = v_m_flit_in ? mQ[0].f : 16'd0;
        m_ctrl_in   = v_m_flit_in ? mQ[0].c : 2'b00;
        v_d_flit_in = (dQ.size() != 0);
        d_flit_in   = v_d_flit_in ? dQ[0].f : 16'd0;
        d_ctrl_in   = v_d_flit_in ? dQ[0].c : 2'b00;
    endtask

    // Per-cycle checks: handshake sanity and scoreboard match on each write.
    task automatic checkOutput();
        flit_t e;
        check("rdy exclusive", 32'(m_rdy & d_rdy), 32'd0);
        check("write enable", 32'(v_flit_out),
              32'((m_rdy & v_m_flit_in) | (d_rdy & v_d_flit_in)));
        if (v_flit_out) begin
            check("scoreboard has entry", 32'(expQ.size() > 0), 32'd1);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("flit_out", 32'(flit_out), 32'(e.f));
                check("ctrl_out", 32'(ctrl_out), 32'(e.c));
            end
        end
    endtask

    // One clock: sample at negedge, retire accepted flits, drive after posedge.
    task automatic tick();
        @(negedge clk);
        checkOutput();
        lastBusy   = arb_busy;
        lastVout   = v_flit_out;
        lastMrdy   = m_rdy;
        lastDrdy   = d_rdy;
        lastOwner  = owner;
        lastCtrl   = ctrl_out;
        lastErrLen = err_len;
        lastErrHdr = err_hdr;
        accM = m_rdy & v_m_flit_in;
        accD = d_rdy & v_d_flit_in;
        @(posedge clk);
        #1;
        if (accM && mQ.size() > 0) void'(mQ.pop_front());
        if (accD && dQ.size() > 0) void'(dQ.pop_front());
        applyStimulus();
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Directed sequence of scenarios.
    initial begin
        logic [3:0] stallPat [6];
        rst = 1'b1;
        fifo_rdy = 1'b1;
        applyStimulus();

        // Reset state.
        doReset();
        check("reset busy", 32'(lastBusy), 32'd0);
        check("reset v_flit_out", 32'(lastVout), 32'd0);
        check("reset m_rdy", 32'(lastMrdy), 32'd0);
        check("reset d_rdy", 32'(lastDrdy), 32'd0);
        check("reset flit_out", 32'(flit_out), 32'd0);
        check("reset ctrl_out", 32'(lastCtrl), 32'd0);
        check("reset owner", 32'(lastOwner), 32'd0);
        check("reset err_len", 32'(lastErrLen), 32'd0);
        check("reset err_hdr", 32'(lastErrHdr), 32'd0);

        // Memory alone, full-length 9-flit packet.
        $display("[TB] memory 9-flit packet");
        pushPacket(1'b0, 9, 16'hA100);
        applyStimulus();
        tick();
        check("t1 idle before grant", 32'(lastBusy), 32'd0);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t1 consecutive write", 32'(lastVout), 32'd1);
            check("t1 busy", 32'(lastBusy), 32'd1);
            check("t1 owner", 32'(lastOwner), 32'd0);
        end
        tick();
        check("t1 back to idle", 32'(lastBusy), 32'd0);
        check("t1 rr_ptr", 32'(dut.r_rr_ptr), 32'd1);
        check("t1 err_len", 32'(lastErrLen), 32'd0);
        check("t1 err_hdr", 32'(lastErrHdr), 32'd0);

        // Both request from reset: memory first, dcache after one idle cycle.
        $display("[TB] simultaneous requests");
        doReset();
        pushPacket(1'b0, 3, 16'hA200);
        pushPacket(1'b1, 3, 16'hD200);
        applyStimulus();
        tick();
        check("t2 idle", 32'(lastBusy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2 m write", 32'(lastVout), 32'd1);
            check("t2 owner m", 32'(lastOwner), 32'd0);
            check("t2 d_rdy low", 32'(lastDrdy), 32'd0);
        end
        tick();
        check("t2 gap idle", 32'(lastBusy), 32'd0);
        check("t2 gap no write", 32'(lastVout), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2 d write", 32'(lastVout), 32'd1);
            check("t2 owner d", 32'(lastOwner), 32'd1);
        end
        tick();
        check("t2 end idle", 32'(lastBusy), 32'd0);

        // FIFO stalls during a memory packet while dcache waits.
        $display("[TB] fifo stalls");
        pushPacket(1'b0, 4, 16'hA300);
        pushPacket(1'b1, 1, 16'hD300);
        applyStimulus();
        tick();
        check("t3 idle", 32'(lastBusy), 32'd0);
        stallPat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1};
        for (int i = 0; i < 6; i++) begin
            fifo_rdy = stallPat[i][0];
            tick();
            check("t3 write follows fifo_rdy", 32'(lastVout), 32'(stallPat[i][0]));
            check("t3 m_rdy follows fifo_rdy", 32'(lastMrdy), 32'(stallPat[i][0]));
            check("t3 d_rdy low", 32'(lastDrdy), 32'd0);
            check("t3 owner m", 32'(lastOwner), 32'd0);
        end
        fifo_rdy = 1'b1;
        tick();
        check("t3 gap idle", 32'(lastBusy), 32'd0);
        tick();
        check("t3 d single write", 32'(lastVout), 32'd1);
        check("t3 owner d", 32'(lastOwner), 32'd1);
        tick();
        check("t3 end idle", 32'(lastBusy), 32'd0);

        // Dcache overruns MAX_FLITS with no tail.
        $display("[TB] length overrun");
        pushFlit(1'b1, 16'hD400, 2'b01, 2'b01, 1'b1);
        for (int i = 1; i < 8; i++) pushFlit(1'b1, 16'hD400 + 16'(i), 2'b10, 2'b10, 1'b1);
        pushFlit(1'b1, 16'hD408, 2'b10, 2'b11, 1'b1);
        pushFlit(1'b1, 16'hD409, 2'b10, 2'b10, 1'b1);
        pushFlit(1'b1, 16'hD40A, 2'b11, 2'b11, 1'b1);
        applyStimulus();
        tick();
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t4 write", 32'(lastVout), 32'd1);
        end
        check("t4 ninth ctrl forced tail", 32'(lastCtrl), 32'd3);
        tick();
        check("t4 idle after cut", 32'(lastBusy), 32'd0);
        check("t4 err_len", 32'(lastErrLen), 32'd1);
        check("t4 err_hdr not yet", 32'(lastErrHdr), 32'd0);
        tick();
        check("t4 tenth write", 32'(lastVout), 32'd1);
        tick();
        check("t4 err_hdr", 32'(lastErrHdr), 32'd1);
        check("t4 closing tail", 32'(lastVout), 32'd1);
        tick();
        check("t4 end idle", 32'(lastBusy), 32'd0);
        check("t4 err_len sticky", 32'(lastErrLen), 32'd1);

        // Single-flit packets: dcache, then memory right behind it.
        $display("[TB] single-flit packets");
        doReset();
        pushPacket(1'b1, 1, 16'hD500);
        applyStimulus();
        tick();
        check("t5 idle", 32'(lastBusy), 32'd0);
        pushPacket(1'b0, 1, 16'hA500);
        applyStimulus();
        tick();
        check("t5 d write", 32'(lastVout), 32'd1);
        check("t5 owner d", 32'(lastOwner), 32'd1);
        check("t5 m_rdy low", 32'(lastMrdy), 32'd0);
        tick();
        check("t5 gap idle", 32'(lastBusy), 32'd0);
        tick();
        check("t5 m write", 32'(lastVout), 32'd1);
        check("t5 owner m", 32'(lastOwner), 32'd0);
        tick();
        check("t5 end idle", 32'(lastBusy), 32'd0);
        check("t5 err_len", 32'(lastErrLen), 32'd0);
        check("t5 err_hdr", 32'(lastErrHdr), 32'd0);
        check("t5 rr_ptr", 32'(dut.r_rr_ptr), 32'd1);

        // Reset on the fourth flit of a memory packet.
        $display("[TB] reset mid-packet");
        pushPacket(1'b0, 4, 16'hA600);
        pushFlit(1'b0, 16'hA604, 2'b10, 2'b10, 1'b0);
        pushFlit(1'b0, 16'hA605, 2'b11, 2'b11, 1'b0);
        applyStimulus();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6 write", 32'(lastVout), 32'd1);
        end
        rst = 1'b1;
        tick();
        check("t6 fourth flit written", 32'(lastVout), 32'd1);
        rst = 1'b0;
        mQ.delete();
        applyStimulus();
        tick();
        check("t6 busy dropped", 32'(lastBusy), 32'd0);
        check("t6 m_rdy", 32'(lastMrdy), 32'd0);
        check("t6 len_cnt", 32'(dut.r_len_cnt), 32'd0);
        check("t6 rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
        check("t6 err_len", 32'(lastErrLen), 32'd0);
        check("t6 err_hdr", 32'(lastErrHdr), 32'd0);

        tick();
        check("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/rep_upload_arb.md
Name: rep_upload_arb

Overview:
- Packet-atomic arbiter sharing the single outgoing reply FIFO of the communication assist between two 16-bit flit uploaders: the memory reply uploader (m_*) and the data-cache reply uploader (d_*).
- Grants one whole packet at a time and holds the grant until the tail flit has been written.
- Uses round-robin priority between packets.
- Checks the flit framing (head / body / tail) and packet length, and reports violations through sticky error flags.

Parameters:
- MAX_FLITS, default 9: maximum number of flits in one packet, including head and tail. Legal range 2..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m_flit_in  in  16  memory uploader flit
- v_m_flit_in  in  1  memory uploader flit valid
- m_ctrl_in  in  2  memory flit type: 01 head, 10 body, 11 tail
- d_flit_in  in  16  dcache uploader flit
- v_d_flit_in  in  1  dcache uploader flit valid
- d_ctrl_in  in  2  dcache flit type, same encoding as m_ctrl_in
- fifo_rdy  in  1  reply FIFO can accept a flit this cycle
- m_rdy  out  1  flit accepted from memory uploader this cycle
- d_rdy  out  1  flit accepted from dcache uploader this cycle
- flit_out  out  16  flit to reply FIFO
- v_flit_out  out  1  FIFO write enable
- ctrl_out  out  2  flit type to FIFO
- arb_busy  out  1  a grant is held (state is not IDLE)
- owner  out  1  current or most recent grantee: 0 = memory, 1 = dcache
- err_len  out  1  sticky: packet exceeded MAX_FLITS
- err_hdr  out  1  sticky: first flit of a packet was not a head or tail

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: state IDLE, rr_ptr=0 (memory favoured), len_cnt=0, owner=0, err_len=0, err_hdr=0.
  - Resulting outputs: v_flit_out=0, m_rdy=0, d_rdy=0, flit_out=0, ctrl_out=00, arb_busy=0.
  - A reset mid-packet drops the grant immediately. No tail is fabricated.
- States: IDLE, GNT_M, GNT_D.
- IDLE:
  - No flit is accepted; both rdy outputs are 0.
  - If only one valid is high, go to that requester's grant state next cycle.
  - If both are high, grant the requester selected by rr_ptr (0 = memory, 1 = dcache).
  - fifo_rdy is not checked in IDLE.
  - owner updates to the grantee on the IDLE-to-grant transition.
- GNT_x (x = owner):
  - Combinational pass-through of the owner's flit and ctrl to flit_out and ctrl_out.
  - x_rdy = fifo_rdy. The non-owner's rdy is 0.
  - xfer = v_x_flit_in & fifo_rdy; v_flit_out = xfer.
  - When not granted, flit_out and ctrl_out are 0.
- Length counter (len_cnt, 4 bits):
  - Increments on each xfer; clears when the packet ends.
  - The first flit is the one with len_cnt==0.
- Header check: if the first flit's ctrl is not 01 and not 11, set err_hdr and still forward the flit.
- Packet end: xfer with ctrl 11 ends the packet. Single-flit packets (first flit ctrl 11) are legal.
- Length overrun: if a xfer occurs with len_cnt==MAX_FLITS-1 and ctrl is not 11:
  - ctrl_out is forced to 11;
  - err_len is set;
  - the packet ends.
- On packet end:
  - next state is IDLE;
  - rr_ptr = ~owner;
  - len_cnt = 0.
- Latency:
  - Request high in IDLE at cycle t gives the first possible transfer at cycle t+1.
  - Back-to-back packets always have one IDLE cycle between them.
  - With fifo_rdy held high, a packet of N flits occupies N+1 cycles.
- Stalls:
  - If fifo_rdy=0 or the owner's valid=0, the grant is held indefinitely with no timeout.
  - The non-owner waits and cannot pre-empt.
- Requester contract: an uploader holds flit, ctrl and valid stable until it sees its rdy.
- ctrl 00 mid-packet is forwarded unchanged and counted as a body flit.
- Error flags are cleared only by rst.

Test Plan:
- Memory uploader alone: 9-flit packet (01, seven 10, 11) with fifo_rdy=1 → arb_busy rises one cycle after valid, nine consecutive v_flit_out with flit and ctrl matching, back to IDLE, rr_ptr=1, no error flags.
- Both uploaders request from reset, each with a 3-flit packet → memory packet transferred first; after one IDLE cycle the dcache packet follows; owner goes 0→1; d_rdy=0 throughout the memory packet.
- fifo_rdy toggled 1,0,0,1 during a memory packet while v_d_flit_in is held high → no writes and m_rdy=0 on the stalled cycles, flits in order, dcache never granted until the memory tail.
- Dcache sends 10 flits with no tail, MAX_FLITS=9 → ninth flit written with ctrl_out=11, err_len=1, state returns to IDLE; the tenth flit is handled as a new packet and sets err_hdr=1.
- Single-flit packet (ctrl 11) from dcache, then immediately from memory → each takes two cycles, no error flags.
- rst asserted on the fourth flit of a memory packet → next cycle arb_busy=0, m_rdy=0, len_cnt=0, rr_ptr=0, error flags 0.
